// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg -- shared 640x480@60 timing constants for the VGA timing
// generator and its axis counters.
//   coord_t          : 10-bit pixel coordinate
//   H_* / V_*        : porch/sync/visible widths and totals
//   *_SYNC_FIRST/LAST: inclusive sync windows as coordinates
package vga_timing_pkg;

  typedef logic [9:0] coord_t;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FP      = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BP      = 48;
  localparam int unsigned H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FP      = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BP      = 33;
  localparam int unsigned V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam coord_t H_VIS_END     = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS_END     = coord_t'(V_VISIBLE);
  localparam coord_t H_SYNC_FIRST  = coord_t'(H_VISIBLE + H_FP);
  localparam coord_t H_SYNC_LAST   = coord_t'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam coord_t V_SYNC_FIRST  = coord_t'(V_VISIBLE + V_FP);
  localparam coord_t V_SYNC_LAST   = coord_t'(V_VISIBLE + V_FP + V_SYNC - 1);

  function automatic logic in_window(coord_t c, coord_t first, coord_t last);
    return (c >= first) && (c <= last);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter -- one axis (H or V) of the raster position.
//   vga_clk : pixel clock
//   reset   : synchronous, active-high; clears count
//   inc     : advance by one this cycle
//   count   : current coordinate, 0..TOTAL-1
//   wrap    : inc is high and count is at TOTAL-1 (count returns to 0 next)
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned TOTAL = 800
) (
  input  logic   vga_clk,
  input  logic   reset,
  input  logic   inc,
  output coord_t count,
  output logic   wrap
);

  localparam coord_t LAST = coord_t'(TOTAL - 1);

  assign wrap = inc && (count == LAST);

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      count <= '0;
    end else if (wrap) begin
      count <= '0;
    end else if (inc) begin
      count <= count + coord_t'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen -- 640x480@60 VGA raster timing generator (25 MHz pixel clock).
//   vga_clk     : pixel clock, all state on rising edge
//   reset       : synchronous, active-high
//   DrawX/DrawY : current pixel column/row
//   hs/vs       : active-low horizontal/vertical sync
//   blank       : 1 in the visible region
//   line_start  : one-cycle pulse on the first pixel of a line
//   frame_start : one-cycle pulse on the first pixel of a frame
//   frame_count : completed frames since reset, modulo 2^16
// Build option: define VGA_SYNC_DELAY_EN to delay hs/vs by one extra cycle,
// for downstream pipelines that register colour one cycle after the address.
module vga_timing_gen
  import vga_timing_pkg::*;
(
  input  logic        vga_clk,
  input  logic        reset,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        hs,
  output logic        vs,
  output logic        blank,
  output logic        frame_start,
  output logic        line_start,
  output logic [15:0] frame_count
);

  coord_t h_count, v_count;
  coord_t h_next, v_next;
  logic   h_wrap, v_wrap;
  logic   hs_q, vs_q;

  vga_axis_counter #(.TOTAL(H_TOTAL)) u_h_cnt (
    .vga_clk (vga_clk),
    .reset   (reset),
    .inc     (1'b1),
    .count   (h_count),
    .wrap    (h_wrap)
  );

  vga_axis_counter #(.TOTAL(V_TOTAL)) u_v_cnt (
    .vga_clk (vga_clk),
    .reset   (reset),
    .inc     (h_wrap),
    .count   (v_count),
    .wrap    (v_wrap)
  );

  // The decoded outputs are registered from the coordinate the counters are
  // about to load, so they appear in the same cycle as that DrawX/DrawY.
  always_comb begin
    h_next = h_wrap ? '0 : h_count + coord_t'(1);
    v_next = v_count;
    if (v_wrap) begin
      v_next = '0;
    end else if (h_wrap) begin
      v_next = v_count + coord_t'(1);
    end
  end

  assign DrawX = h_count;
  assign DrawY = v_count;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      blank       <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      hs_q        <= ~in_window(h_next, H_SYNC_FIRST, H_SYNC_LAST);
      vs_q        <= ~in_window(v_next, V_SYNC_FIRST, V_SYNC_LAST);
      blank       <= (h_next < H_VIS_END) && (v_next < V_VIS_END);
      // Pulses come from the wraps, so the reset cycle's 0,0 never pulses.
      line_start  <= h_wrap;
      frame_start <= v_wrap;
      frame_count <= frame_count + {15'd0, v_wrap};
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  logic hs_d, vs_d;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hs_d <= 1'b1;
      vs_d <= 1'b1;
    end else begin
      hs_d <= hs_q;
      vs_d <= vs_q;
    end
  end

  assign hs = hs_d;
  assign vs = vs_d;
`else
  assign hs = hs_q;
  assign vs = vs_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  logic        vga_clk = 1'b0;
  logic        reset   = 1'b1;
  logic [9:0]  DrawX, DrawY;
  logic        hs, vs, blank, frame_start, line_start;
  logic [15:0] frame_count;

  always #20 vga_clk = ~vga_clk;

  vga_timing_gen dut (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .hs          (hs),
    .vs          (vs),
    .blank       (blank),
    .frame_start (frame_start),
    .line_start  (line_start),
    .frame_count (frame_count)
  );

`ifdef VGA_SYNC_DELAY_EN
  localparam int SD = 1;
`else
  localparam int SD = 0;
`endif

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: raster position advanced by plain arithmetic.
  int mh = 0, mv = 0, ph = 0, pv = 0;
  int mfc = 0;
  bit mrst = 1'b1, mls = 1'b0, mfs = 1'b0;

  function automatic bit hs_of(int h);
    return !(h >= 656 && h <= 751);
  endfunction

  function automatic bit vs_of(int v);
    return !(v >= 490 && v <= 491);
  endfunction

  function automatic bit blank_of(int h, int v);
    return (h < 640) && (v < 480);
  endfunction

  task automatic model_step(input bit r);
    ph = mh;
    pv = mv;
    if (r) begin
      mh = 0; mv = 0; mfc = 0; mls = 0; mfs = 0; mrst = 1;
    end else begin
      mh = mh + 1;
      if (mh == 800) begin
        mh = 0;
        mv = mv + 1;
        if (mv == 525) mv = 0;
      end
      mls  = (mh == 0);
      mfs  = mls && (mv == 0);
      if (mfs) mfc = (mfc + 1) % 65536;
      mrst = 0;
    end
  endtask

  task automatic check_model();
    logic [40:0] act, exp;
    bit ehs, evs;
    if (SD != 0) begin
      ehs = mrst ? 1'b1 : hs_of(ph);
      evs = mrst ? 1'b1 : vs_of(pv);
    end else begin
      ehs = hs_of(mh);
      evs = vs_of(mv);
    end
    act = {DrawX, DrawY, hs, vs, blank, line_start, frame_start, frame_count};
    exp = {10'(mh), 10'(mv), ehs, evs, blank_of(mh, mv), mls, mfs, 16'(mfc)};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL model at x=%0d y=%0d: got %h, expected %h", mh, mv, act, exp);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit r);
    @(negedge vga_clk);
    reset = r;
    @(posedge vga_clk);
    model_step(r);
    #1;
  endtask

  task automatic cyc(input bit r);
    drive(r);
    check_model();
  endtask

  // Call away from the clock edge; the new row takes effect at the next edge.
  task automatic jump_v(input int target);
    force dut.u_v_cnt.count = 10'(target);
    release dut.u_v_cnt.count;
    mv = target;
  endtask

  typedef struct {
    bit rst;
    int x; int y;
    bit hs; bit vs; bit blank; bit ls; bit fs;
    int fc;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int hs_lo, first_hs, last_hs, first_bl, cycles, vlow, bhigh, prev_fc;

    tbl[0] = '{1, 0, 0, 1, 1, 1, 0, 0, 0};
    tbl[1] = '{1, 0, 0, 1, 1, 1, 0, 0, 0};
    tbl[2] = '{1, 0, 0, 1, 1, 1, 0, 0, 0};
    tbl[3] = '{0, 1, 0, 1, 1, 1, 0, 0, 0};
    tbl[4] = '{0, 2, 0, 1, 1, 1, 0, 0, 0};
    tbl[5] = '{0, 3, 0, 1, 1, 1, 0, 0, 0};

    // Reset hold and release.
    for (int i = 0; i < 6; i++) begin
      logic [40:0] act, exp;
      drive(tbl[i].rst);
      act = {DrawX, DrawY, hs, vs, blank, line_start, frame_start, frame_count};
      exp = {10'(tbl[i].x), 10'(tbl[i].y), tbl[i].hs, tbl[i].vs, tbl[i].blank,
             tbl[i].ls, tbl[i].fs, 16'(tbl[i].fc)};
      vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("FAIL reset_vec[%0d]: got %h, expected %h", i, act, exp);
      end
    end

    // One full line.
    found = 0; hs_lo = 0; first_hs = -1; last_hs = -1; first_bl = -1;
    for (int i = 0; i < 900 && !found; i++) begin
      cyc(0);
      if (DrawX == 10'd0) begin
        found = 1;
      end else begin
        if (!hs) begin
          hs_lo++;
          if (first_hs < 0) first_hs = int'(DrawX);
          last_hs = int'(DrawX);
        end
        if (!blank && first_bl < 0) first_bl = int'(DrawX);
      end
    end
    chk("line_wrap_reached", int'(found), 1);
    chk("hs_low_cycles", hs_lo, 96);
    chk("hs_first_low_x", first_hs, 656 + SD);
    chk("hs_last_low_x", last_hs, 751 + SD);
    chk("blank_first_zero_x", first_bl, 640);
    chk("line_start_at_wrap", int'(line_start), 1);
    chk("drawy_after_line", int'(DrawY), 1);

    // Rest of a frame: skip to the end of row 469, then run to the frame edge.
    found = 0;
    for (int i = 0; i < 900 && !found; i++) begin
      cyc(0);
      if (DrawX == 10'd799) found = 1;
    end
    chk("reach_x799", int'(found), 1);
    jump_v(469);
    found = 0; cycles = 0; vlow = 0; bhigh = 0;
    for (int i = 0; i < 45000 && !found; i++) begin
      cyc(0);
      cycles++;
      if (!vs) vlow++;
      if (blank) bhigh++;
      if (frame_start) found = 1;
    end
    chk("frame_start_reached", int'(found), 1);
    chk("cycles_to_frame_start", cycles, 55 * 800 + 1);
    chk("vs_low_cycles", vlow, 1600);
    // rows 470..479 visible, plus the 0,0 pixel of the new frame
    chk("blank_high_cycles", bhigh, 10 * 640 + 1);
    chk("frame_count_after_frame", int'(frame_count), 1);
    chk("line_start_with_frame", int'(line_start), 1);
    cyc(0);
    chk("frame_start_one_cycle", int'(frame_start), 0);

    // Reset mid-frame at x=300, y=200.
    jump_v(200);
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      cyc(0);
      if (DrawX == 10'd300) found = 1;
    end
    chk("reach_x300", int'(found), 1);
    chk("row_200", int'(DrawY), 200);
    cyc(1);
    chk("midreset_x", int'(DrawX), 0);
    chk("midreset_y", int'(DrawY), 0);
    chk("midreset_fc", int'(frame_count), 0);
    chk("midreset_fs", int'(frame_start), 0);
    cyc(0);
    chk("postreset_x", int'(DrawX), 1);
    chk("postreset_ls", int'(line_start), 0);

    // frame_count wrap from 0xFFFF.
    force dut.frame_count = 16'hFFFF;
    release dut.frame_count;
    mfc = 16'hFFFF;
    jump_v(524);
    found = 0; prev_fc = -1;
    for (int i = 0; i < 1000 && !found; i++) begin
      prev_fc = int'(frame_count);
      cyc(0);
      if (frame_start) found = 1;
    end
    chk("wrap_frame_start_reached", int'(found), 1);
    chk("fc_before_wrap", prev_fc, 16'hFFFF);
    chk("fc_wrapped", int'(frame_count), 0);

    // Random reset pulses against the model.
    for (int k = 0; k < 10; k++) begin
      int n, r;
      n = int'($urandom_range(1, 1500));
      r = int'($urandom_range(1, 3));
      for (int i = 0; i < n; i++) cyc(0);
      for (int i = 0; i < r; i++) cyc(1);
    end
    for (int i = 0; i < 5; i++) cyc(0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Port vga_clk, input, 1 bit: pixel clock, 25.0 MHz nominal; all state updates on its rising edge.
REQ-002 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 Port DrawX, output, 10 bits: current pixel column, 0..799.
REQ-004 Port DrawY, output, 10 bits: current pixel row, 0..524.
REQ-005 Port hs, output, 1 bit: horizontal sync, active-low.
REQ-006 Port vs, output, 1 bit: vertical sync, active-low.
REQ-007 Port blank, output, 1 bit: 1 = visible region (colour may be driven), 0 = blanked.
REQ-008 Port frame_start, output, 1 bit: one-cycle pulse at the first pixel of each frame.
REQ-009 Port line_start, output, 1 bit: one-cycle pulse at the first pixel of each line.
REQ-010 Port frame_count, output, 16 bits: number of completed frames since reset, modulo 2^16.

Function
REQ-011 The horizontal counter SHALL increment every cycle, from 0 to 799, and wrap to 0.
REQ-012 The vertical counter SHALL increment only in the cycle where the horizontal counter wraps; it counts 0 to 524, then wraps to 0.
REQ-013 Horizontal timing SHALL be: visible 0-639, front porch 640-655, sync 656-751, back porch 752-799.
REQ-014 Vertical timing SHALL be: visible 0-479, front porch 480-489, sync 490-491, back porch 492-524.
REQ-015 All outputs SHALL be registered (no combinational path from the counters to the ports).
REQ-016 In any cycle showing DrawX=h and DrawY=v, the outputs SHALL satisfy:
- hs = ~(656<=h<=751)
- vs = ~(490<=v<=491)
- blank = (h<640 && v<480)
REQ-017 line_start SHALL be 1 iff DrawX=0 and the previous cycle was not in reset.
REQ-018 frame_start SHALL be 1 iff DrawX=0, DrawY=0 and the previous cycle was not in reset.
REQ-019 frame_count SHALL increment by 1 in the same cycle that frame_start is 1, and wrap from 0xFFFF to 0x0000.
REQ-020 DrawX and DrawY SHALL be presented with zero latency relative to blank, so a downstream sprite stage can compute its ROM address and gate its colour with blank.

Reset
REQ-021 While reset is 1, the outputs SHALL be: DrawX=0, DrawY=0, hs=1, vs=1, blank=1, frame_start=0, line_start=0, frame_count=0.
REQ-022 Reset asserted mid-frame SHALL take effect at the next rising edge, with no partial-line completion.
REQ-023 In the first cycle after reset deasserts, the outputs SHALL be: DrawX=1, DrawY=0, with no start pulses.

Configuration
REQ-024 With macro VGA_SYNC_DELAY_EN defined, hs and vs SHALL each pass through one extra register stage:
- they then lag DrawX/DrawY/blank by exactly 1 cycle, matching a downstream stage that registers colour one cycle after the address;
- the delay registers SHALL reset to 1.
REQ-025 Without VGA_SYNC_DELAY_EN, hs and vs SHALL be aligned with DrawX/DrawY per REQ-016; all other behaviour is identical in both builds.

Structure
REQ-026 Shared package vga_timing_pkg SHALL hold:
- localparams H_VISIBLE=640, H_FP=16, H_SYNC=96, H_BP=48, H_TOTAL=800;
- localparams V_VISIBLE=480, V_FP=10, V_SYNC=2, V_BP=33, V_TOTAL=525;
- typedef coord_t (10-bit logic).
REQ-027 Sub-module vga_axis_counter (parameter TOTAL; inputs vga_clk, reset, inc; outputs count, wrap) SHALL be instantiated once for H (inc=1) and once for V (inc=H wrap).

Verification
REQ-028 Reset is held 3 cycles, then released. Each cycle during reset shows DrawX=0, DrawY=0, hs=1, vs=1, blank=1, frame_count=0. In the first cycle after release, DrawX=1.
REQ-029 Run one full line.
- hs=0 exactly for DrawX 656..751 (96 cycles).
- blank=0 from DrawX=640.
- line_start pulses when DrawX returns to 0.
- DrawY increments from 0 to 1.
REQ-030 Run one full frame (420000 cycles).
- vs=0 for exactly 1600 cycles (DrawY 490..491).
- blank=1 for exactly 307200 cycles.
- frame_start pulses once, and frame_count becomes 1.
REQ-031 Assert reset at DrawX=300, DrawY=200 for 1 cycle. The next cycle shows DrawX=0, DrawY=0, frame_count=0, frame_start=0.
REQ-032 Build with VGA_SYNC_DELAY_EN. The first hs=0 cycle occurs when DrawX=657, and the last when DrawX=752; vs behaves likewise.
REQ-033 Preload frame_count=0xFFFF via force, then run to the next frame boundary. frame_count wraps to 0x0000 in the frame_start cycle.
